// File: rtl/up_reg_bank.sv
// up_reg_bank: local-bus register bank with version, scratch, control, status and W1C interrupt registers
module up_reg_bank #(
    parameter int                G_CPUA   = 30,
    parameter int                G_CPUW   = 32,
    parameter int                NUM_CTRL = 4,
    parameter int                NUM_STAT = 4,
    parameter logic [G_CPUW-1:0] VERSION  = 32'h0001_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [G_CPUA-1:0]            upa,
    input  logic                         upen,
    input  logic                         upws,
    input  logic                         uprs,
    input  logic [G_CPUW-1:0]            updi,
    output logic [G_CPUW-1:0]            updo,
    output logic                         uprdy,
    output logic [NUM_CTRL*G_CPUW-1:0]   ctrl_o,
    output logic [NUM_CTRL-1:0]          ctrl_upd,
    input  logic [NUM_STAT*G_CPUW-1:0]   stat_i,
    input  logic [G_CPUW-1:0]            int_evt,
    output logic                         irq
);
    localparam int CW = NUM_CTRL > 1 ? $clog2(NUM_CTRL) : 1;
    localparam int SW = NUM_STAT > 1 ? $clog2(NUM_STAT) : 1;
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nx;
    logic is_ctrl, is_stat, mapped, acc, wr, rd, w1c;
    logic [CW-1:0] ci;
    logic [SW-1:0] si;
    logic [G_CPUW-1:0] rd_mux, rdata, scratch, sticky, mask;
    always_comb begin
        ci       = CW'(upa - G_CPUA'(4));
        si       = SW'(upa - G_CPUA'(16));
        is_ctrl  = upa >= G_CPUA'(4) && upa < G_CPUA'(4 + NUM_CTRL);
        is_stat  = upa >= G_CPUA'(16) && upa < G_CPUA'(16 + NUM_STAT);
        mapped   = upa < G_CPUA'(4) || is_ctrl || is_stat;
        acc      = state == IDLE && upen && (upws || uprs) && mapped;
        wr       = acc && upws;
        rd       = acc && !upws;
        w1c      = wr && upa == G_CPUA'(2);
        state_nx = acc ? ACK : IDLE;
        rd_mux   = upa == G_CPUA'(0) ? VERSION :
                   upa == G_CPUA'(1) ? scratch :
                   upa == G_CPUA'(2) ? sticky  :
                   upa == G_CPUA'(3) ? mask    :
                   is_ctrl ? ctrl_o[ci*G_CPUW +: G_CPUW] :
                   is_stat ? stat_i[si*G_CPUW +: G_CPUW] : '0;
    end
    // ack is gated by rst so a reset landing in the ACK cycle suppresses it immediately
    assign uprdy = state == ACK && !rst;
    assign updo  = uprdy ? rdata : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rdata    <= '0;
            scratch  <= '0;
            sticky   <= '0;
            mask     <= '0;
            ctrl_o   <= '0;
            ctrl_upd <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nx;
            rdata    <= rd ? rd_mux : '0;
            ctrl_upd <= (wr && is_ctrl) ? NUM_CTRL'(1) << ci : '0;
            sticky   <= (sticky & ~(w1c ? updi : '0)) | int_evt;
            irq      <= |(sticky & mask);
            if (wr && upa == G_CPUA'(1)) scratch <= updi;
            if (wr && upa == G_CPUA'(3)) mask <= updi;
            if (wr && is_ctrl) ctrl_o[ci*G_CPUW +: G_CPUW] <= updi;
        end
    end
endmodule

// File: tb/tb_up_reg_bank.sv
// tb_up_reg_bank: table-driven and directed checks of the up_reg_bank access FSM and registers
module tb_up_reg_bank;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [29:0]  upa = '0;
    logic         upen = 1'b0, upws = 1'b0, uprs = 1'b0;
    logic [31:0]  updi = '0;
    logic [31:0]  updo;
    logic         uprdy;
    logic [127:0] ctrl_o;
    logic [3:0]   ctrl_upd;
    logic [127:0] stat_i = {32'h4444_3333, 32'h3333_2222, 32'h2222_1111, 32'h1111_0000};
    logic [31:0]  int_evt = '0;
    logic         irq;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    up_reg_bank dut (
        .clk(clk), .rst(rst), .upa(upa), .upen(upen), .upws(upws), .uprs(uprs),
        .updi(updi), .updo(updo), .uprdy(uprdy), .ctrl_o(ctrl_o), .ctrl_upd(ctrl_upd),
        .stat_i(stat_i), .int_evt(int_evt), .irq(irq)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [29:0] a;
        logic [31:0] d;
        logic        ack;
        logic [31:0] dout;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic w, input logic r, input logic [29:0] a, input logic [31:0] d);
        upen = 1'b1; upws = w; uprs = r; upa = a; updi = d;
        step();
        upws = 1'b0; uprs = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [29:0] a, input logic [31:0] exp);
        strobe(1'b0, 1'b1, a, '0);
        chk({name, "_ack"}, uprdy, 1'b1);
        chk(name, updo, exp);
        upen = 1'b0;
        step();
    endtask

    task automatic wr_do(input logic [29:0] a, input logic [31:0] d);
        strobe(1'b1, 1'b0, a, d);
        upen = 1'b0;
        step();
    endtask

    initial begin
        int acks;
        vecs[0]  = '{0, 1, 30'h00, 32'h0,         1, 32'h0001_0000};
        vecs[1]  = '{1, 0, 30'h01, 32'hDEAD_BEEF, 1, 32'h0};
        vecs[2]  = '{0, 1, 30'h01, 32'h0,         1, 32'hDEAD_BEEF};
        vecs[3]  = '{1, 0, 30'h04, 32'h5,         1, 32'h0};
        vecs[4]  = '{0, 1, 30'h04, 32'h0,         1, 32'h5};
        vecs[5]  = '{1, 0, 30'h07, 32'hA5A5_5A5A, 1, 32'h0};
        vecs[6]  = '{0, 1, 30'h07, 32'h0,         1, 32'hA5A5_5A5A};
        vecs[7]  = '{0, 1, 30'h10, 32'h0,         1, 32'h1111_0000};
        vecs[8]  = '{0, 1, 30'h13, 32'h0,         1, 32'h4444_3333};
        vecs[9]  = '{1, 0, 30'h00, 32'h1234_5678, 1, 32'h0};
        vecs[10] = '{0, 1, 30'h00, 32'h0,         1, 32'h0001_0000};
        vecs[11] = '{1, 0, 30'h10, 32'h9999_9999, 1, 32'h0};
        vecs[12] = '{0, 1, 30'h10, 32'h0,         1, 32'h1111_0000};
        vecs[13] = '{0, 1, 30'h08, 32'h0,         0, 32'h0};
        vecs[14] = '{0, 1, 30'h14, 32'h0,         0, 32'h0};

        repeat (3) step();
        chk("rst_uprdy", uprdy, 1'b0);
        chk("rst_updo", updo, 32'h0);
        chk("rst_ctrl_o", ctrl_o, 128'h0);
        chk("rst_ctrl_upd", ctrl_upd, 4'h0);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            strobe(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_ack", i), uprdy, vecs[i].ack);
            if (vecs[i].r) chk($sformatf("vec%0d_data", i), updo, vecs[i].dout);
            upen = 1'b0;
            step();
            chk($sformatf("vec%0d_idle_rdy", i), uprdy, 1'b0);
            chk($sformatf("vec%0d_idle_do", i), updo, 32'h0);
        end
        rd_chk("mask_init", 30'h03, 32'h0);
        rd_chk("sticky_init", 30'h02, 32'h0);

        strobe(1'b1, 1'b0, 30'h04, 32'h5);
        chk("ctrl_upd_pulse", ctrl_upd, 4'b0001);
        chk("ctrl0_value", ctrl_o[31:0], 32'h5);
        chk("ctrl3_value", ctrl_o[127:96], 32'hA5A5_5A5A);
        upen = 1'b0;
        step();
        chk("ctrl_upd_clear", ctrl_upd, 4'b0000);

        int_evt = 32'h8;
        step();
        int_evt = 32'h0;
        step();
        rd_chk("sticky_set", 30'h02, 32'h8);
        chk("irq_masked", irq, 1'b0);
        strobe(1'b1, 1'b0, 30'h03, 32'h8);
        chk("irq_lag", irq, 1'b0);
        upen = 1'b0;
        step();
        chk("irq_set", irq, 1'b1);
        strobe(1'b1, 1'b0, 30'h02, 32'h8);
        upen = 1'b0;
        step();
        chk("irq_cleared", irq, 1'b0);
        rd_chk("sticky_cleared", 30'h02, 32'h0);

        int_evt = 32'h8;
        step();
        int_evt = 32'h8;
        strobe(1'b1, 1'b0, 30'h02, 32'h8);
        int_evt = 32'h0;
        upen = 1'b0;
        step();
        rd_chk("evt_beats_w1c", 30'h02, 32'h8);
        chk("irq_after_race", irq, 1'b1);

        upen = 1'b1; uprs = 1'b1; upa = 30'h3F;
        step();
        uprs = 1'b0;
        acks = 0;
        repeat (300) begin
            if (uprdy) acks++;
            step();
        end
        chk("unmapped_no_ack", acks, 0);
        upen = 1'b0;
        step();
        rd_chk("unmapped_scratch", 30'h01, 32'hDEAD_BEEF);

        strobe(1'b1, 1'b1, 30'h01, 32'h0BAD_F00D);
        chk("wr_rd_ack", uprdy, 1'b1);
        upen = 1'b0;
        step();
        chk("wr_rd_single", uprdy, 1'b0);
        rd_chk("wr_rd_scratch", 30'h01, 32'h0BAD_F00D);

        strobe(1'b0, 1'b1, 30'h00, 32'h0);
        upen = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ack_uprdy", uprdy, 1'b0);
        chk("rst_ack_updo", updo, 32'h0);
        step();
        rst = 1'b0;
        chk("rst2_ctrl_o", ctrl_o, 128'h0);
        chk("rst2_irq", irq, 1'b0);
        chk("rst2_uprdy", uprdy, 1'b0);
        step();
        chk("rst2_no_ack", uprdy, 1'b0);
        rd_chk("rst2_scratch", 30'h01, 32'h0);
        rd_chk("rst2_sticky", 30'h02, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
